// File: rtl/sw_led_logic_unit_pkg.sv
// Shared LED mode encoding and the constant clog2 used to size debounce counters.
package sw_led_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_HOLD   = 2'b01,
    MODE_TOGGLE = 2'b10,
    MODE_RSVD   = 2'b11
  } led_mode_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sw_led_logic_unit_if.sv
// Switch/mode inputs and LED/debounced-switch outputs of the switch-to-LED stage.
interface sw_led_logic_unit_if #(
  parameter int N_SW  = 4,
  parameter int N_LED = 3
);
  logic [N_SW-1:0]  sw;
  logic [1:0]       mode;
  logic [N_LED-1:0] led;
  logic [N_SW-1:0]  sw_db;
  logic             led_change;

  modport master (output sw, output mode, input led, input sw_db, input led_change);
  modport slave  (input sw, input mode, output led, output sw_db, output led_change);
endinterface

// File: rtl/sw_led_logic_unit_debounce.sv
// One switch bit: 2-flop synchroniser then a counter that accepts a change only
// after it has persisted for DEBOUNCE_CYCLES consecutive edges.
module sw_debounce
  import sw_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic q
);

  localparam int CW = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter tops out at DEBOUNCE_CYCLES-1, so it can never wrap.
  always_comb begin
    meta_d = d_async;
    sync_d = meta_q;
    db_d   = db_q;
    cnt_d  = '0;
    if (sync_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = ~db_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  assign q = db_q;

endmodule

// File: rtl/sw_led_logic_unit.sv
// Debounced switches index one truth table per LED; LEDs are registered in
// direct, hold or rising-edge toggle mode, with a pulse whenever they change.
module sw_led_logic_unit
  import sw_led_pkg::*;
#(
  parameter int                          N_SW            = 4,
  parameter int                          N_LED           = 3,
  parameter int                          DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [N_LED*(2**N_SW)-1:0] LED_LUT         = 48'hFC00_F000_000F
) (
  input logic               clk,
  input logic               rst,
  sw_led_logic_unit_if.slave io
);

  localparam int W = 2 ** N_SW;

  logic [N_SW-1:0]  sw_db;
  logic [N_LED-1:0] f;
  logic [N_LED-1:0] f_prev_q, f_prev_d;
  logic [N_LED-1:0] led_q, led_d;
  logic             led_change_q, led_change_d;

  for (genvar i = 0; i < N_SW; i++) begin : gen_db
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .d_async(io.sw[i]),
      .q      (sw_db[i])
    );
  end

  for (genvar k = 0; k < N_LED; k++) begin : gen_lut
    localparam logic [W-1:0] TT = LED_LUT[k*W +: W];
    assign f[k] = TT[sw_db];
  end

  // f_prev tracks f in every mode so entering toggle never sees a stale edge.
  always_comb begin
    f_prev_d = f;
    led_d    = led_q;
    case (led_mode_e'(io.mode))
      MODE_DIRECT: led_d = f;
      MODE_TOGGLE: led_d = led_q ^ (f & ~f_prev_q);
      default:     led_d = led_q;
    endcase
    led_change_d = (led_d != led_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_prev_q     <= '0;
      led_q        <= '0;
      led_change_q <= 1'b0;
    end else begin
      f_prev_q     <= f_prev_d;
      led_q        <= led_d;
      led_change_q <= led_change_d;
    end
  end

  assign io.led        = led_q;
  assign io.sw_db      = sw_db;
  assign io.led_change = led_change_q;

endmodule
